// File: rtl/adder_rr_scheduler_if.sv
// Request/response bundle between the client blocks and the shared-adder scheduler.
interface adder_rr_scheduler_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_sub;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_sum;
  logic              rsp_ovf;
  logic              busy;

  modport master (
    output req_valid, req_a, req_b, req_sub, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_ovf, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sub, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_ovf, busy
  );
endinterface

// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one 8-bit signed ripple adder between NREQ requesters.
// Each operation runs IDLE (grant) -> EXEC (add) -> RESP (hold until consumed).

// 8-bit ripple adder; Cout reports signed overflow rather than the raw carry out.
module full_Adder (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] Sum,
  output logic       Cout
);
  logic [8:0] carry;

  // Ripple bit by bit; overflow is the carry into the MSB differing from the carry out of it.
  always_comb begin
    carry    = '0;
    carry[0] = Cin;
    Sum      = '0;
    for (int i = 0; i < 8; i++) begin
      Sum[i]       = A[i] ^ B[i] ^ carry[i];
      carry[i+1]   = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end
    Cout = carry[8] ^ carry[7];
  end
endmodule

module adder_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  adder_rr_scheduler_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]     a_q, a_d;
  logic [7:0]     b_q, b_d;
  logic           sub_q, sub_d;
  logic [IDW-1:0] id_q, id_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [7:0]     rsp_sum_q, rsp_sum_d;
  logic           rsp_ovf_q, rsp_ovf_d;

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] scan_idx;
  logic [7:0]     sel_a, sel_b;
  logic           sel_sub;
  logic           accept;
  logic [7:0]     add_b, add_sum;
  logic           add_ovf;

  // Round-robin search starting at rr_ptr; wraps at NREQ, which need not be a power of two.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = rr_ptr_q;
    for (int j = 0; j < NREQ; j++) begin
      if (!grant_found && bus.req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
      scan_idx = (scan_idx == IDW'(NREQ - 1)) ? '0 : scan_idx + 1'b1;
    end
  end

  // Pick the granted requester's payload out of the flattened operand buses.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (grant_idx == IDW'(j)) begin
        sel_a   = bus.req_a[8*j +: 8];
        sel_b   = bus.req_b[8*j +: 8];
        sel_sub = bus.req_sub[j];
      end
    end
  end

  assign accept = (state_q == IDLE) && grant_found;

  // Subtraction is A + ~B + 1, so the shared adder serves both operations.
  assign add_b = sub_q ? ~b_q : b_q;

  full_Adder u_adder (
    .A    (a_q),
    .B    (add_b),
    .Cin  (sub_q),
    .Sum  (add_sum),
    .Cout (add_ovf)
  );

  // FSM state register; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: one cycle of execution, then wait for the response to be consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_found) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_valid_q && bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: the grant is only offered while idle and out of reset.
  always_comb begin
    bus.req_ready = '0;
    if (state_q == IDLE && grant_found && rst_n) bus.req_ready[grant_idx] = 1'b1;
    bus.busy = (state_q != IDLE);
  end

  // Datapath next values: latch operands on accept, capture the result in EXEC, retire on handshake.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_ovf_d   = rsp_ovf_q;
    if (accept) begin
      a_d      = sel_a;
      b_d      = sel_b;
      sub_d    = sel_sub;
      id_d     = grant_idx;
      rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
    if (state_q == EXEC) begin
      rsp_sum_d   = add_sum;
      rsp_ovf_d   = add_ovf;
      rsp_id_d    = id_q;
      rsp_valid_d = 1'b1;
    end
    if (state_q == RESP && rsp_valid_q && bus.rsp_ready) rsp_valid_d = 1'b0;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_ovf_q   <= rsp_ovf_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Testbench for adder_rr_scheduler: transaction-level model plus directed and random traffic.
module tb_adder_rr_scheduler;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   hs_count = 0;
  int   glog_id[$];
  int   glog_cyc[$];

  // Model state: pending op between grant and result, and the response currently offered.
  int         m_ptr = 0;
  bit         m_pending = 1'b0;
  bit         m_rsp_valid = 1'b0;
  logic [7:0] m_a = '0;
  logic [7:0] m_b = '0;
  bit         m_sub = 1'b0;
  int         m_id = 0;
  logic [7:0] m_rsp_sum = '0;
  bit         m_rsp_ovf = 1'b0;
  int         m_rsp_id = 0;

  adder_rr_scheduler_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  adder_rr_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic int pickGrant(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [8:0] calcResult(input logic [7:0] a, input logic [7:0] b, input bit sub);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = sub ? sa - sb : sa + sb;
    return {(r > 127 || r < -128), r[7:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [31:0] a, input logic [31:0] b,
                               input logic [NREQ-1:0] sub, input logic rr);
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_sub   = sub;
    bus.rsp_ready = rr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    int n;
    applyStimulus('0, '0, '0, '0, 1'b1);
    n = 0;
    while (bus.busy && n < 10) begin
      tick();
      n++;
    end
    checkOutput("drain_idle", 32'(bus.busy), 32'd0);
  endtask

  task automatic runOp(input int id, input logic [7:0] a, input logic [7:0] b, input logic sub,
                       output logic [7:0] s, output logic o, output logic [IDW-1:0] rid, output bit ok);
    int n;
    ok  = 1'b0;
    s   = '0;
    o   = 1'b0;
    rid = '0;
    applyStimulus(NREQ'(1) << id, 32'(a) << (8 * id), 32'(b) << (8 * id), NREQ'(sub) << id, 1'b1);
    n = 0;
    while (!bus.req_ready[id] && n < 20) begin
      tick();
      n++;
    end
    if (bus.req_ready[id]) begin
      tick();
      applyStimulus('0, '0, '0, '0, 1'b1);
      n = 0;
      while (!bus.rsp_valid && n < 20) begin
        tick();
        n++;
      end
      if (bus.rsp_valid) begin
        s   = bus.rsp_sum;
        o   = bus.rsp_ovf;
        rid = bus.rsp_id;
        ok  = 1'b1;
        tick();
      end
    end else begin
      applyStimulus('0, '0, '0, '0, 1'b1);
    end
  endtask

  // Cycle counter used to time grants.
  always @(posedge clk) cyc++;

  // Reference model: advance one transaction step per clock from the sampled inputs.
  always @(posedge clk or negedge rst_n) begin
    int g;
    logic [8:0] res;
    if (!rst_n) begin
      m_ptr       = 0;
      m_pending   = 1'b0;
      m_rsp_valid = 1'b0;
      m_rsp_sum   = '0;
      m_rsp_ovf   = 1'b0;
      m_rsp_id    = 0;
    end else if (m_rsp_valid) begin
      if (bus.rsp_ready) m_rsp_valid = 1'b0;
    end else if (m_pending) begin
      res         = calcResult(m_a, m_b, m_sub);
      m_rsp_sum   = res[7:0];
      m_rsp_ovf   = res[8];
      m_rsp_id    = m_id;
      m_rsp_valid = 1'b1;
      m_pending   = 1'b0;
    end else begin
      g = pickGrant(bus.req_valid, m_ptr);
      if (g >= 0) begin
        m_a       = bus.req_a[8*g +: 8];
        m_b       = bus.req_b[8*g +: 8];
        m_sub     = bus.req_sub[g];
        m_id      = g;
        m_ptr     = (g + 1) % NREQ;
        m_pending = 1'b1;
      end
    end
  end

  // Compare DUT outputs against the model mid-cycle, and log grants and handshakes.
  always @(negedge clk) begin
    logic [NREQ-1:0] er;
    int g;
    er = '0;
    if (rst_n && !m_pending && !m_rsp_valid) begin
      g = pickGrant(bus.req_valid, m_ptr);
      if (g >= 0) er = NREQ'(1) << g;
    end
    checkOutput("req_ready", 32'(bus.req_ready), 32'(er));
    checkOutput("busy", 32'(bus.busy), 32'(m_pending || m_rsp_valid));
    checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(m_rsp_valid));
    checkOutput("rsp_id", 32'(bus.rsp_id), 32'(m_rsp_id));
    checkOutput("rsp_sum", 32'(bus.rsp_sum), 32'(m_rsp_sum));
    if (m_rsp_valid) checkOutput("rsp_ovf", 32'(bus.rsp_ovf), 32'(m_rsp_ovf));
    for (int k = 0; k < NREQ; k++) begin
      if (bus.req_ready[k]) begin
        glog_id.push_back(k);
        glog_cyc.push_back(cyc);
      end
    end
    if (rst_n && bus.rsp_valid && bus.rsp_ready) hs_count++;
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    logic [7:0]     cs_a[5]   = '{8'h7F, 8'h80, 8'h00, 8'h80, 8'hFF};
    logic [7:0]     cs_b[5]   = '{8'h01, 8'h01, 8'h80, 8'h80, 8'h01};
    logic           cs_sub[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0]     cs_sum[5] = '{8'h80, 8'h7F, 8'h80, 8'h00, 8'h00};
    logic           cs_ovf[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int             exp_order[6] = '{0, 1, 2, 3, 0, 1};
    logic [7:0]     s;
    logic           o;
    logic [IDW-1:0] rid;
    bit             ok;
    int             gstart, gcount0, hs0, n;

    // Pin the model's arithmetic and search order to hand-computed values.
    checkOutput("pin_7f_add_01", 32'(calcResult(8'h7F, 8'h01, 1'b0)), 32'h180);
    checkOutput("pin_00_sub_80", 32'(calcResult(8'h00, 8'h80, 1'b1)), 32'h180);
    checkOutput("pin_ff_add_01", 32'(calcResult(8'hFF, 8'h01, 1'b0)), 32'h000);
    checkOutput("pin_grant_wrap", 32'(pickGrant(4'b1001, 1)), 32'd3);
    checkOutput("pin_grant_wrap0", 32'(pickGrant(4'b0011, 2)), 32'd0);

    // Reset state.
    rst_n = 1'b0;
    applyStimulus('0, '0, '0, '0, 1'b1);
    repeat (2) tick();
    checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("reset_rsp_sum", 32'(bus.rsp_sum), 32'd0);
    checkOutput("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;

    // Single ADD on requester 0.
    $display("[TB] single add");
    gcount0 = glog_id.size();
    applyStimulus(4'b0001, 32'h05, 32'h03, '0, 1'b1);
    checkOutput("single_req_ready", 32'(bus.req_ready), 32'h1);
    tick();
    applyStimulus('0, '0, '0, '0, 1'b1);
    checkOutput("single_ready_low", 32'(bus.req_ready), 32'h0);
    checkOutput("single_busy", 32'(bus.busy), 32'd1);
    tick();
    checkOutput("single_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    checkOutput("single_rsp_sum", 32'(bus.rsp_sum), 32'h08);
    checkOutput("single_rsp_ovf", 32'(bus.rsp_ovf), 32'd0);
    checkOutput("single_rsp_id", 32'(bus.rsp_id), 32'd0);
    tick();
    checkOutput("single_rsp_done", 32'(bus.rsp_valid), 32'd0);
    checkOutput("single_grant_pulses", 32'(glog_id.size() - gcount0), 32'd1);

    // Overflow boundary cases on rotating requesters.
    $display("[TB] overflow cases");
    for (int i = 0; i < 5; i++) begin
      runOp(i % NREQ, cs_a[i], cs_b[i], cs_sub[i], s, o, rid, ok);
      checkOutput($sformatf("ovf_case%0d_done", i), 32'(ok), 32'd1);
      checkOutput($sformatf("ovf_case%0d_sum", i), 32'(s), 32'(cs_sum[i]));
      checkOutput($sformatf("ovf_case%0d_ovf", i), 32'(o), 32'(cs_ovf[i]));
      checkOutput($sformatf("ovf_case%0d_id", i), 32'(rid), 32'(i % NREQ));
    end

    // All requesters valid: grant order and spacing.
    $display("[TB] round robin");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    gstart = glog_id.size();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(4'hF, $urandom, $urandom, 4'($urandom), 1'b1);
      tick();
    end
    drain();
    checkOutput("rr_grant_count", 32'(glog_id.size() >= gstart + 6), 32'd1);
    if (glog_id.size() >= gstart + 6) begin
      for (int i = 0; i < 6; i++) begin
        checkOutput($sformatf("rr_order%0d", i), 32'(glog_id[gstart + i]), 32'(exp_order[i]));
        if (i > 0) checkOutput($sformatf("rr_spacing%0d", i),
                               32'(glog_cyc[gstart + i] - glog_cyc[gstart + i - 1]), 32'd3);
      end
    end

    // Response back-pressure for five cycles.
    $display("[TB] back-pressure");
    applyStimulus(4'b1000, 32'h11 << 24, 32'h22 << 24, '0, 1'b0);
    n = 0;
    while (!bus.req_ready[3] && n < 20) begin
      tick();
      n++;
    end
    checkOutput("bp_granted", 32'(bus.req_ready), 32'h8);
    tick();
    applyStimulus(4'b0111, $urandom, $urandom, 4'($urandom), 1'b0);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      checkOutput("bp_rsp_sum", 32'(bus.rsp_sum), 32'h33);
      checkOutput("bp_rsp_id", 32'(bus.rsp_id), 32'd3);
      checkOutput("bp_rsp_ovf", 32'(bus.rsp_ovf), 32'd0);
      checkOutput("bp_req_ready", 32'(bus.req_ready), 32'd0);
      checkOutput("bp_busy", 32'(bus.busy), 32'd1);
      tick();
    end
    hs0 = hs_count;
    applyStimulus('0, '0, '0, '0, 1'b1);
    tick();
    checkOutput("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("bp_release_busy", 32'(bus.busy), 32'd0);
    checkOutput("bp_one_handshake", 32'(hs_count - hs0), 32'd1);
    checkOutput("bp_hold_sum", 32'(bus.rsp_sum), 32'h33);

    // Reset during EXEC drops the operation and restarts the pointer.
    $display("[TB] reset mid-operation");
    applyStimulus(4'b0100, 32'h7F << 16, 32'h01 << 16, '0, 1'b1);
    checkOutput("rst_grant2", 32'(bus.req_ready), 32'h4);
    tick();
    checkOutput("rst_in_exec", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    applyStimulus('0, '0, '0, '0, 1'b1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checkOutput("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
      tick();
    end
    applyStimulus(4'hF, $urandom, $urandom, 4'($urandom), 1'b1);
    checkOutput("rst_ptr_restart", 32'(bus.req_ready), 32'h1);
    tick();
    drain();

    // Randomized traffic with occasional back-pressure and two resets.
    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      if (i == 137 || i == 290) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      applyStimulus(($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom), $urandom, $urandom,
                    4'($urandom), $urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end
endmodule
